// File: rtl/mmio_req_arbiter_if.sv
// Opcode encoding and the request/response bundle shared by the requesters,
// the arbiter and the single MMIO port.
package mmio_req_arbiter_pkg;
    typedef logic [2:0] t_opcode;
    localparam t_opcode RD     = 3'd0;
    localparam t_opcode WR     = 3'd1;
    localparam t_opcode RD_RSP = 3'd2;
    localparam t_opcode WR_RSP = 3'd3;
endpackage

interface mmio_req_arbiter_if #(parameter int NUM_REQ = 2);
    import mmio_req_arbiter_pkg::*;

    logic    [NUM_REQ-1:0]       ReqValid;
    logic    [NUM_REQ-1:0]       ReqReady;
    t_opcode [NUM_REQ-1:0]       ReqOpcode;
    logic    [NUM_REQ-1:0][31:0] ReqAddress;
    logic    [NUM_REQ-1:0][31:0] ReqData;
    logic    [NUM_REQ-1:0]       RspValid;
    t_opcode                     RspOpcode;
    logic    [31:0]              RspData;
    logic                        RspErr;
    logic                        MmioReqValid;
    t_opcode                     MmioReqOpcode;
    logic    [31:0]              MmioReqAddr;
    logic    [31:0]              MmioReqData;
    logic                        MmioRspValid;
    t_opcode                     MmioRspOpcode;
    logic    [31:0]              MmioRspData;
    logic                        StrayRsp;

    modport slave (
        input  ReqValid, ReqOpcode, ReqAddress, ReqData,
               MmioRspValid, MmioRspOpcode, MmioRspData,
        output ReqReady, RspValid, RspOpcode, RspData, RspErr,
               MmioReqValid, MmioReqOpcode, MmioReqAddr, MmioReqData, StrayRsp
    );

    modport master (
        output ReqValid, ReqOpcode, ReqAddress, ReqData,
               MmioRspValid, MmioRspOpcode, MmioRspData,
        input  ReqReady, RspValid, RspOpcode, RspData, RspErr,
               MmioReqValid, MmioReqOpcode, MmioReqAddr, MmioReqData, StrayRsp
    );
endinterface

// File: rtl/mmio_req_arbiter.sv
// Round-robin arbiter sharing one MMIO request/response port between NUM_REQ
// requesters, one transaction outstanding, with a response timeout.
//
// state    | meaning
// IDLE     | waiting for a request; grant offered combinationally
// ISSUE    | one-cycle MMIO request pulse (or immediate error for bad opcode)
// WAIT_RSP | waiting for the MMIO response or the timeout
module mmio_req_arbiter
    import mmio_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              QClk,
    input  logic              RstQnnnL,
    mmio_req_arbiter_if.slave if_arb
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} t_state;

    t_state             r_state, w_state_nxt;
    logic [IDW-1:0]     r_last, r_id;
    logic [IDW-1:0]     w_grant_id, w_hi_id, w_lo_id;
    logic               w_hi_vld, w_lo_vld, w_grant_vld;
    logic               w_accept, w_legal, w_rsp_ok, w_rsp_to, w_rsp_ill;
    t_opcode            r_op;
    logic [31:0]        r_addr, r_data;
    logic [TW-1:0]      r_timer;
    logic [NUM_REQ-1:0] r_rsp_valid;
    t_opcode            r_rsp_op;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err, r_stray;

    // Rotating priority: lowest requester above LastGrant, else lowest overall.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_id  = '0;
        w_lo_vld = 1'b0;
        w_lo_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (if_arb.ReqValid[i]) begin
                w_lo_vld = 1'b1;
                w_lo_id  = IDW'(i);
                if (IDW'(i) > r_last) begin
                    w_hi_vld = 1'b1;
                    w_hi_id  = IDW'(i);
                end
            end
        end
        w_grant_vld = w_lo_vld;
        w_grant_id  = w_hi_vld ? w_hi_id : w_lo_id;
    end

    assign w_legal = (r_op == RD) || (r_op == WR);

    always_comb begin
        w_state_nxt         = r_state;
        w_accept            = 1'b0;
        w_rsp_ok            = 1'b0;
        w_rsp_to            = 1'b0;
        w_rsp_ill           = 1'b0;
        if_arb.ReqReady     = '0;
        if_arb.MmioReqValid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    if_arb.ReqReady = NUM_REQ'(1) << w_grant_id;
                    w_accept        = 1'b1;
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (w_legal) begin
                    if_arb.MmioReqValid = 1'b1;
                    w_state_nxt         = WAIT_RSP;
                end else begin
                    w_rsp_ill   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_RSP: begin
                // A response arriving on the threshold cycle takes priority.
                if (if_arb.MmioRspValid) begin
                    w_rsp_ok    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_timer >= TLAST) begin
                    w_rsp_to    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            r_last      <= IDW'(NUM_REQ - 1);
            r_id        <= '0;
            r_op        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_timer     <= '0;
            r_rsp_valid <= '0;
            r_rsp_op    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_stray     <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_id   <= w_grant_id;
                r_last <= w_grant_id;
                r_op   <= if_arb.ReqOpcode[w_grant_id];
                r_addr <= if_arb.ReqAddress[w_grant_id];
                r_data <= if_arb.ReqData[w_grant_id];
            end
            if (r_state == ISSUE) begin
                r_timer <= '0;
            end else if (r_state == WAIT_RSP && r_timer != TMAX) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_rsp_ok) begin
                r_rsp_valid <= NUM_REQ'(1) << r_id;
                r_rsp_op    <= if_arb.MmioRspOpcode;
                r_rsp_data  <= if_arb.MmioRspData;
                r_rsp_err   <= 1'b0;
            end else if (w_rsp_to) begin
                r_rsp_valid <= NUM_REQ'(1) << r_id;
                r_rsp_op    <= (r_op == RD) ? RD_RSP : WR_RSP;
                r_rsp_data  <= '0;
                r_rsp_err   <= 1'b1;
            end else if (w_rsp_ill) begin
                r_rsp_valid <= NUM_REQ'(1) << r_id;
                r_rsp_data  <= '0;
                r_rsp_err   <= 1'b1;
            end
            if (if_arb.MmioRspValid && r_state != WAIT_RSP) r_stray <= 1'b1;
        end
    end

    assign if_arb.RspValid      = r_rsp_valid;
    assign if_arb.RspOpcode     = r_rsp_op;
    assign if_arb.RspData       = r_rsp_data;
    assign if_arb.RspErr        = r_rsp_err;
    assign if_arb.MmioReqOpcode = r_op;
    assign if_arb.MmioReqAddr   = r_addr;
    assign if_arb.MmioReqData   = r_data;
    assign if_arb.StrayRsp      = r_stray;
endmodule

// File: tb/tb_mmio_req_arbiter.sv
// Self-checking bench for mmio_req_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mmio_req_arbiter;
    import mmio_req_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int TMO  = 16;

    logic QClk = 1'b0;
    logic RstQnnnL = 1'b0;
    always #5 QClk = ~QClk;

    mmio_req_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    mmio_req_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .QClk    (QClk),
        .RstQnnnL(RstQnnnL),
        .if_arb  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        bus.ReqValid      = '0;
        bus.ReqOpcode     = '0;
        bus.ReqAddress    = '0;
        bus.ReqData       = '0;
        bus.MmioRspValid  = 1'b0;
        bus.MmioRspOpcode = '0;
        bus.MmioRspData   = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ReqReady"},     32'(bus.ReqReady), 0);
        chk({tag, "_RspValid"},     32'(bus.RspValid), 0);
        chk({tag, "_RspOpcode"},    32'(bus.RspOpcode), 0);
        chk({tag, "_RspData"},      bus.RspData, 0);
        chk({tag, "_RspErr"},       32'(bus.RspErr), 0);
        chk({tag, "_MmioReqValid"}, 32'(bus.MmioReqValid), 0);
        chk({tag, "_MmioReqAddr"},  bus.MmioReqAddr, 0);
        chk({tag, "_MmioReqData"},  bus.MmioReqData, 0);
        chk({tag, "_StrayRsp"},     32'(bus.StrayRsp), 0);
    endtask

    task automatic do_reset();
        @(negedge QClk);
        RstQnnnL = 1'b0;
        clear_inputs();
        #1;
        chk_all_zero("reset");
        @(negedge QClk);
        RstQnnnL = 1'b1;
    endtask

    function automatic bit is_legal(input t_opcode op);
        return (op == RD) || (op == WR);
    endfunction

    typedef struct {
        int          id;
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rsp_at;   // cycle offset of the MMIO response, -1 = silent
        t_opcode     rsp_op;
        logic [31:0] rdata;
        int          exp_lat;  // cycle offset of RspValid
        logic        exp_err;
        bit          chk_op;
        t_opcode     exp_op;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, RD, 32'h00FF_0004, 32'h0, 3, RD_RSP, 32'h1234_5678, 4, 1'b0, 1'b1, RD_RSP, 32'h1234_5678};
        vecs[1] = '{1, WR, 32'hA000_0010, 32'hDEAD_BEEF, -1, RD_RSP, 32'h0, 18, 1'b1, 1'b1, WR_RSP, 32'h0};
        vecs[2] = '{0, RD, 32'h0000_0004, 32'h0, 17, RD_RSP, 32'hCAFE_F00D, 18, 1'b0, 1'b1, RD_RSP, 32'hCAFE_F00D};
        vecs[3] = '{1, RD, 32'h0000_0100, 32'h0, -1, RD_RSP, 32'h0, 18, 1'b1, 1'b1, RD_RSP, 32'h0};
        vecs[4] = '{0, 3'd5, 32'h0000_0200, 32'h55AA_55AA, -1, RD_RSP, 32'h0, 2, 1'b1, 1'b0, RD_RSP, 32'h0};
        vecs[5] = '{1, WR, 32'h0000_0300, 32'h0BAD_F00D, 2, WR_RSP, 32'h0000_0000, 3, 1'b0, 1'b1, WR_RSP, 32'h0};

        clear_inputs();

        // Round-robin with both requesters held valid
        do_reset();
        begin
            int grants[$];
            bit rsp_next = 1'b0;
            for (int c = 0; c < 40 && grants.size() < 4; c++) begin
                @(negedge QClk);
                bus.ReqValid      = 2'b11;
                bus.ReqOpcode[0]  = RD;
                bus.ReqOpcode[1]  = RD;
                bus.ReqAddress[0] = 32'h10;
                bus.ReqAddress[1] = 32'h20;
                bus.MmioRspValid  = rsp_next;
                bus.MmioRspOpcode = RD_RSP;
                bus.MmioRspData   = 32'h100 + 32'(c);
                #1;
                rsp_next = bus.MmioReqValid;
                chk("rr_ready_both", 32'(bus.ReqReady == 2'b11), 0);
                if (bus.ReqReady != 2'b00) begin
                    if (grants.size() > 0)
                        chk("rr_rsp_route", 32'(bus.RspValid), 32'(1) << grants[$]);
                    grants.push_back(bus.ReqReady[1] ? 1 : 0);
                end
            end
            chk("rr_grant_count", 32'(grants.size()), 4);
            for (int i = 0; i < grants.size(); i++)
                chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        end

        // Directed vector table
        do_reset();
        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c <= vecs[v].exp_lat + 1; c++) begin
                @(negedge QClk);
                clear_inputs();
                if (c == 0) begin
                    bus.ReqValid[vecs[v].id]   = 1'b1;
                    bus.ReqOpcode[vecs[v].id]  = vecs[v].op;
                    bus.ReqAddress[vecs[v].id] = vecs[v].addr;
                    bus.ReqData[vecs[v].id]    = vecs[v].wdata;
                end
                if (c == vecs[v].rsp_at) begin
                    bus.MmioRspValid  = 1'b1;
                    bus.MmioRspOpcode = vecs[v].rsp_op;
                    bus.MmioRspData   = vecs[v].rdata;
                end
                #1;
                chk($sformatf("v%0d_ready_c%0d", v, c), 32'(bus.ReqReady),
                    (c == 0) ? (32'(1) << vecs[v].id) : 0);
                chk($sformatf("v%0d_mmio_vld_c%0d", v, c), 32'(bus.MmioReqValid),
                    32'(c == 1 && is_legal(vecs[v].op)));
                chk($sformatf("v%0d_rsp_vld_c%0d", v, c), 32'(bus.RspValid),
                    (c == vecs[v].exp_lat) ? (32'(1) << vecs[v].id) : 0);
                if (c == 1 && is_legal(vecs[v].op)) begin
                    chk($sformatf("v%0d_mmio_op", v),   32'(bus.MmioReqOpcode), 32'(vecs[v].op));
                    chk($sformatf("v%0d_mmio_addr", v), bus.MmioReqAddr, vecs[v].addr);
                    chk($sformatf("v%0d_mmio_data", v), bus.MmioReqData, vecs[v].wdata);
                end
                if (c == vecs[v].exp_lat) begin
                    chk($sformatf("v%0d_rsp_err", v),  32'(bus.RspErr), 32'(vecs[v].exp_err));
                    chk($sformatf("v%0d_rsp_data", v), bus.RspData, vecs[v].exp_data);
                    if (vecs[v].chk_op)
                        chk($sformatf("v%0d_rsp_op", v), 32'(bus.RspOpcode), 32'(vecs[v].exp_op));
                end
                if (c == vecs[v].exp_lat + 1) begin
                    chk($sformatf("v%0d_rsp_data_hold", v), bus.RspData, vecs[v].exp_data);
                    chk($sformatf("v%0d_rsp_err_hold", v),  32'(bus.RspErr), 32'(vecs[v].exp_err));
                end
            end
        end

        // Stray MMIO response while idle
        @(negedge QClk);
        clear_inputs();
        bus.MmioRspValid = 1'b1;
        bus.MmioRspData  = 32'h7777_7777;
        #1;
        chk("stray_before", 32'(bus.StrayRsp), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge QClk);
            clear_inputs();
            #1;
            chk($sformatf("stray_rspvld_c%0d", c), 32'(bus.RspValid), 0);
            chk($sformatf("stray_set_c%0d", c), 32'(bus.StrayRsp), 1);
        end

        // Reset during WAIT_RSP, then the late response is stray
        for (int c = 0; c < 4; c++) begin
            @(negedge QClk);
            clear_inputs();
            if (c == 0) begin
                bus.ReqValid[0]   = 1'b1;
                bus.ReqOpcode[0]  = RD;
                bus.ReqAddress[0] = 32'h0000_0ABC;
            end
            #1;
            if (c == 1) chk("rstw_mmio_pulse", 32'(bus.MmioReqValid), 1);
        end
        @(negedge QClk);
        RstQnnnL = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        @(negedge QClk);
        RstQnnnL = 1'b1;
        @(negedge QClk);
        bus.MmioRspValid  = 1'b1;
        bus.MmioRspOpcode = RD_RSP;
        bus.MmioRspData   = 32'h4444_4444;
        #1;
        chk("rstw_late_rspvld0", 32'(bus.RspValid), 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge QClk);
            clear_inputs();
            #1;
            chk($sformatf("rstw_late_rspvld_c%0d", c), 32'(bus.RspValid), 0);
            chk($sformatf("rstw_late_stray_c%0d", c), 32'(bus.StrayRsp), 1);
        end

        // Randomized traffic against a transaction-level model
        do_reset();
        begin
            bit          pend[NREQ];
            t_opcode     pop[NREQ];
            logic [31:0] paddr[NREQ], pdata[NREQ];
            bit          busy = 1'b0;
            int          m_last = NREQ - 1;
            int          cur = 0;
            t_opcode     cur_op = RD;
            logic [31:0] cur_addr = '0, cur_data = '0;
            int          issue_c = -1, mrsp_c = -1, rsp_c = -1;
            t_opcode     m_rsp_op = RD_RSP, e_op = RD_RSP;
            logic [31:0] m_rdata = '0, e_data = '0;
            logic        e_err = 1'b0;
            bit          e_chk_op = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                pend[i] = 1'b0; pop[i] = RD; paddr[i] = '0; pdata[i] = '0;
            end
            for (int c = 0; c < 1500; c++) begin
                int g;
                logic [31:0] exp_rv;
                @(negedge QClk);
                for (int i = 0; i < NREQ; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        int r;
                        r = int'($urandom_range(0, 9));
                        pend[i]  = 1'b1;
                        pop[i]   = (r < 4) ? RD : (r < 8) ? WR : t_opcode'(3'd4 + 3'($urandom_range(0, 3)));
                        paddr[i] = $urandom;
                        pdata[i] = $urandom;
                    end
                    bus.ReqValid[i]   = pend[i];
                    bus.ReqOpcode[i]  = pop[i];
                    bus.ReqAddress[i] = paddr[i];
                    bus.ReqData[i]    = pdata[i];
                end
                bus.MmioRspValid  = (c == mrsp_c);
                bus.MmioRspOpcode = m_rsp_op;
                bus.MmioRspData   = m_rdata;
                #1;
                exp_rv = 0;
                if (busy && c == rsp_c) begin
                    exp_rv = 32'(1) << cur;
                    busy   = 1'b0;
                end
                chk("rnd_rsp_vld", 32'(bus.RspValid), exp_rv);
                if (exp_rv != 0) begin
                    chk("rnd_rsp_err",  32'(bus.RspErr), 32'(e_err));
                    chk("rnd_rsp_data", bus.RspData, e_data);
                    if (e_chk_op) chk("rnd_rsp_op", 32'(bus.RspOpcode), 32'(e_op));
                end
                chk("rnd_mmio_vld", 32'(bus.MmioReqValid), 32'(c == issue_c && is_legal(cur_op)));
                if (c == issue_c && is_legal(cur_op)) begin
                    chk("rnd_mmio_op",   32'(bus.MmioReqOpcode), 32'(cur_op));
                    chk("rnd_mmio_addr", bus.MmioReqAddr, cur_addr);
                    chk("rnd_mmio_data", bus.MmioReqData, cur_data);
                end
                g = -1;
                if (!busy)
                    for (int k = 1; k <= NREQ; k++)
                        if (g < 0 && pend[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
                chk("rnd_ready", 32'(bus.ReqReady), (g >= 0) ? (32'(1) << g) : 0);
                if (g >= 0) begin
                    m_last   = g;
                    busy     = 1'b1;
                    cur      = g;
                    cur_op   = pop[g];
                    cur_addr = paddr[g];
                    cur_data = pdata[g];
                    pend[g]  = 1'b0;
                    issue_c  = c + 1;
                    mrsp_c   = -1;
                    if (is_legal(cur_op)) begin
                        int k;
                        k        = int'($urandom_range(1, TMO + 4));
                        e_chk_op = 1'b1;
                        if (k <= TMO) begin
                            mrsp_c   = c + 1 + k;
                            m_rsp_op = (cur_op == RD) ? RD_RSP : WR_RSP;
                            m_rdata  = $urandom;
                            rsp_c    = c + 2 + k;
                            e_err    = 1'b0;
                            e_data   = m_rdata;
                            e_op     = m_rsp_op;
                        end else begin
                            rsp_c  = c + 2 + TMO;
                            e_err  = 1'b1;
                            e_data = '0;
                            e_op   = (cur_op == RD) ? RD_RSP : WR_RSP;
                        end
                    end else begin
                        rsp_c    = c + 2;
                        e_err    = 1'b1;
                        e_data   = '0;
                        e_chk_op = 1'b0;
                    end
                end
            end
            chk("rnd_no_stray", 32'(bus.StrayRsp), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
